csa_pipe_adder: RTL
===================

Name: csa_pipe_adder

Overview:
Parametrised, pipelined carry-select adder. It is the successor to the fixed 64-bit, 4-block carry-select adder. WIDTH is split into NBLK blocks of BLK_W bits, with one pipeline stage per block, so it sustains one add per cycle at a clock rate set by a single BLK_W-bit ripple. It adds a valid/ready handshake on both sides, so it can sit in streaming datapaths such as accumulators and ALU back-ends.

Parameters:
WIDTH, 64, operand/sum width in bits; must be a multiple of BLK_W
BLK_W, 16, carry-select block width; NBLK = WIDTH/BLK_W, NBLK >= 1

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
a  in  WIDTH  operand A (unsigned)
b  in  WIDTH  operand B (unsigned)
cin  in  1  carry in
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  WIDTH  (a+b+cin) mod 2^WIDTH
cout  out  1  carry out of MSB

Behaviour:
- Reset (rst=1 at posedge): all stage valid bits cleared; all data registers cleared.
  - out_valid=0, sum=0, cout=0.
  - in_ready=1 in the first cycle after reset.
- Reset mid-operation: all in-flight beats are discarded and never emitted.
- Stage k (0..NBLK-1) computes block k.
  - Two BLK_W ripple sums are formed: one with carry-in 0, one with carry-in 1.
  - The carry registered by stage k-1 selects between them; stage 0 uses cin.
  - Stage k registers: selected block sum, block carry-out, lower sum bits already resolved, and the unprocessed upper operand bits of a/b.
- Latency: exactly NBLK cycles from an accepted input (in_valid & in_ready) to out_valid, when there is no backpressure. Throughput is 1 beat/cycle.
- Flow control uses a global advance = !out_valid || out_ready.
  - in_ready = advance.
  - All stages shift when advance=1 and hold when advance=0.
  - Bubbles are not collapsed.
- Input acceptance:
  - A beat is accepted only when in_valid & in_ready.
  - If in_valid=1 and in_ready=0, the input is not captured; the source must hold it.
  - If in_valid=0 on an advance cycle, a bubble (valid=0) enters stage 0.
- Output: sum/cout are registered and stable while out_valid & !out_ready. A result is consumed on out_valid & out_ready.
- Arithmetic: unsigned. Overflow wraps modulo 2^WIDTH, with the carry reported on cout.
  - Example: all-ones + 0 + cin=1 gives sum=0, cout=1.
- Degenerate case BLK_W=WIDTH: one stage, latency 1.
- Elaboration error if WIDTH % BLK_W != 0.

Optional Feature:
CSA_OVF_EN:
- Defined:
  - Adds output port ovf (1 bit), registered with sum.
  - ovf = signed two's-complement overflow = carry into MSB XOR cout.
  - ovf resets to 0 and holds under stall like sum.
- Undefined:
  - Port absent; no extra logic.

Decomposition:
- Package csa_pkg: WIDTH/BLK_W defaults, function nblk(width, blk_w), and a stage payload struct/typedef. The payload holds valid, resolved-sum bits, carry, remaining a/b bits, and the ovf carry-in tap.
- Sub-module csa_block (natural): combinational BLK_W dual ripple adder plus select mux. Ports: a, b, csel → s, co, c_msb_in (for ovf).
- csa_pipe_adder instantiates NBLK csa_block instances and the stage registers and handshake.

Test Plan:
1. WIDTH=64, BLK_W=16. Accept a=2, b=5, cin=0, out_ready=1 → out_valid exactly 4 cycles later with sum=7, cout=0.
2. Cross-block carry chain:
   - a=0x0000_0000_FFFF_FFFF, b=1, cin=0 → sum=0x0000_0001_0000_0000.
   - a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → sum=0, cout=1.
3. Streaming: 10 back-to-back beats → 10 results on consecutive cycles in order.
   - Beats: (2,5,0), (1,1,0), (12,12,1), (12,12,0), (75,75,1), (1024,2048,0), (4096,8192,0), (22000,2000,0), (2223000,2021312300,0), (9213123,99812398123,0).
   - Results: 7, 2, 25, 24, 151, 3072, 12288, 24000, 2023535300, 99821611246.
4. Backpressure: stream continuously and drop out_ready for 3 cycles.
   - in_ready is low those cycles; sum/out_valid hold stable.
   - No beat is lost or duplicated; order is preserved.
5. Reset mid-flight: accept 3 beats, assert rst 1 cycle before the first result.
   - out_valid=0 and sum=0 for the next ≥4 cycles; none of the 3 results ever appear.
   - A new beat 3+4=7 is then emitted normally.
6. With CSA_OVF_EN defined:
   - a=0x7FFF_FFFF_FFFF_FFFF + b=1 → ovf=1, cout=0.
   - a=0x8000_0000_0000_0000 + b=0x8000_0000_0000_0000 → sum=0, cout=1, ovf=1.
   - 2+5 → ovf=0.

Source files
------------

// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared defaults, block-count helper and stage control payload for csa_pipe_adder
package csa_pkg;

    localparam int CSA_WIDTH_DEF = 64;
    localparam int CSA_BLK_W_DEF = 16;

    function automatic int nblk(input int width, input int blk_w);
        return width / blk_w;
    endfunction

    // Control half of a stage payload; resolved sum and remaining operands live in per-stage data registers
    typedef struct packed {
        logic valid;
        logic carry;
    } csa_ctrl_t;

endpackage

// File: rtl/csa_block.sv
// rtl/csa_block.sv - BLK_W-bit dual ripple adder (carry-in 0 and 1) with carry-select mux
module csa_block #(
    parameter int BLK_W = 16
) (
    input  logic [BLK_W-1:0] a,
    input  logic [BLK_W-1:0] b,
    input  logic             csel,
    output logic [BLK_W-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [BLK_W:0]   c0;
    logic [BLK_W:0]   c1;
    logic [BLK_W-1:0] s0;
    logic [BLK_W-1:0] s1;

    always_comb begin
        c0    = '0;
        c1    = '0;
        s0    = '0;
        s1    = '0;
        c1[0] = 1'b1;
        for (int i = 0; i < BLK_W; i++) begin
            s0[i]   = a[i] ^ b[i] ^ c0[i];
            c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
            s1[i]   = a[i] ^ b[i] ^ c1[i];
            c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
        end
    end

    assign s        = csel ? s1 : s0;
    assign co       = csel ? c1[BLK_W] : c0[BLK_W];
    assign c_msb_in = csel ? c1[BLK_W-1] : c0[BLK_W-1];

endmodule

// File: rtl/csa_pipe_adder.sv
// rtl/csa_pipe_adder.sv - pipelined carry-select adder, one stage per block, valid/ready on both sides
// Optional signed-overflow output ovf when CSA_OVF_EN is defined.
module csa_pipe_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH_DEF,
    parameter int BLK_W = CSA_BLK_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef CSA_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NBLK = nblk(WIDTH, BLK_W);

    if (BLK_W < 1 || WIDTH % BLK_W != 0) begin : g_bad_cfg
        $error("csa_pipe_adder: WIDTH must be a non-zero multiple of BLK_W");
    end

    csa_ctrl_t        ctl_q  [NBLK];
    csa_ctrl_t        ctl_in [NBLK];
    logic [WIDTH-1:0] a_q    [NBLK];
    logic [WIDTH-1:0] b_q    [NBLK];
    logic [WIDTH-1:0] s_q    [NBLK];
    logic [WIDTH-1:0] a_in   [NBLK];
    logic [WIDTH-1:0] b_in   [NBLK];
    logic [WIDTH-1:0] s_in   [NBLK];
    logic [BLK_W-1:0] blk_s  [NBLK];
    logic             blk_co [NBLK];
    logic             blk_cm [NBLK];
    logic             advance;

    assign advance   = !ctl_q[NBLK-1].valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = ctl_q[NBLK-1].valid;
    assign sum       = s_q[NBLK-1];
    assign cout      = ctl_q[NBLK-1].carry;

    // Operands shift down one block per stage so every stage adds the low BLK_W bits
    always_comb begin
        a_in[0]         = a;
        b_in[0]         = b;
        s_in[0]         = '0;
        ctl_in[0].valid = in_valid;
        ctl_in[0].carry = cin;
        for (int k = 1; k < NBLK; k++) begin
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            s_in[k]   = s_q[k-1];
            ctl_in[k] = ctl_q[k-1];
        end
    end

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        csa_block #(.BLK_W(BLK_W)) u_blk (
            .a        (a_in[k][BLK_W-1:0]),
            .b        (b_in[k][BLK_W-1:0]),
            .csel     (ctl_in[k].carry),
            .s        (blk_s[k]),
            .co       (blk_co[k]),
            .c_msb_in (blk_cm[k])
        );
    end

    // Resolved block sums enter at the top and shift down, so block 0 lands in the LSBs at the end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NBLK; k++) begin
                ctl_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < NBLK; k++) begin
                ctl_q[k].valid <= ctl_in[k].valid;
                if (ctl_in[k].valid) begin
                    ctl_q[k].carry <= blk_co[k];
                    a_q[k]         <= a_in[k] >> BLK_W;
                    b_q[k]         <= b_in[k] >> BLK_W;
                    s_q[k]         <= (s_in[k] >> BLK_W) | (WIDTH'(blk_s[k]) << (WIDTH - BLK_W));
                end
            end
        end
    end

`ifdef CSA_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (advance && ctl_in[NBLK-1].valid) begin
            ovf_q <= blk_cm[NBLK-1] ^ blk_co[NBLK-1];
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_cm_tap;

    always_comb begin
        unused_cm_tap = 1'b0;
        for (int k = 0; k < NBLK; k++) begin
            unused_cm_tap = unused_cm_tap ^ blk_cm[k];
        end
    end
`endif

endmodule
